// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request port and an aligned-word memory port.
// Builds byte enables and lane-shifted store data, and extends load data.
module mem_access_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_rsp_valid,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_misaligned
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic                store_r, unsigned_r, misaligned_r;
  logic [1:0]          size_r;
  logic [OFF_W-1:0]    off_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [STRB_W-1:0]   be_r, be_s;
  logic [XLEN-1:0]     wdata_r, rdata_r, wdata_s, ext_s;
  logic                accept_s, fault_s;

  function automatic logic is_fault(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic f;
    case (size)
      2'b00:   f = 1'b0;
      2'b01:   f = off[0];
      2'b10:   f = (off[1:0] != 2'b00);
      2'b11:   f = (XLEN == 32) ? 1'b1 : (off != {OFF_W{1'b0}});
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [STRB_W-1:0] calc_be(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic [STRB_W-1:0] ones;
    ones = ~({STRB_W{1'b1}} << (32'd1 << size));
    return ones << off;
  endfunction

  // Keeps the low (8 << size) bits of d and fills the rest with the sign or zero.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [1:0] size,
                                             input logic uns);
    logic [XLEN-1:0] keep;
    logic            s;
    case (size)
      2'b00:   s = d[7];
      2'b01:   s = d[15];
      2'b10:   s = d[31];
      default: s = d[XLEN-1];
    endcase
    if (uns) s = 1'b0;
    else     s = s;
    keep = ~({XLEN{1'b1}} << (32'd8 << size));
    if (size == 2'b11) keep = {XLEN{1'b1}};
    else               keep = keep;
    return (d & keep) | ({XLEN{s}} & ~keep);
  endfunction

  assign accept_s = (state_r == IDLE) && req_valid;
  assign fault_s  = is_fault(req_size, req_addr[OFF_W-1:0]);
  assign be_s     = calc_be(req_size, req_addr[OFF_W-1:0]);
  assign wdata_s  = req_wdata << {req_addr[OFF_W-1:0], 3'b000};
  assign ext_s    = extend(mem_rdata >> {off_r, 3'b000}, size_r, unsigned_r);

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) state_s = fault_s ? DONE : REQ;
        else           state_s = IDLE;
      end
      REQ: begin
        if (mem_req_ready) state_s = store_r ? DONE : WAIT;
        else               state_s = REQ;
      end
      WAIT: begin
        if (mem_rsp_valid) state_s = DONE;
        else               state_s = WAIT;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register plus the request captured at accept and the load result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      store_r      <= 1'b0;
      unsigned_r   <= 1'b0;
      misaligned_r <= 1'b0;
      size_r       <= 2'b00;
      off_r        <= {OFF_W{1'b0}};
      addr_r       <= {ADDR_W{1'b0}};
      be_r         <= {STRB_W{1'b0}};
      wdata_r      <= {XLEN{1'b0}};
      rdata_r      <= {XLEN{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        store_r      <= req_store;
        unsigned_r   <= req_unsigned;
        misaligned_r <= fault_s;
        size_r       <= req_size;
        off_r        <= req_addr[OFF_W-1:0];
        addr_r       <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        be_r         <= fault_s ? {STRB_W{1'b0}} : be_s;
        wdata_r      <= wdata_s;
        rdata_r      <= {XLEN{1'b0}};
      end else if ((state_r == WAIT) && mem_rsp_valid) begin
        rdata_r <= ext_s;
      end
    end
  end

  // Every output comes from state or a register; nothing passes through from an input.
  assign req_ready      = (state_r == IDLE);
  assign mem_req_valid  = (state_r == REQ);
  assign mem_we         = (state_r == REQ) && store_r;
  assign mem_be         = (state_r == REQ) ? be_r : {STRB_W{1'b0}};
  assign mem_addr       = addr_r;
  assign mem_wdata      = wdata_r;
  assign rsp_valid      = (state_r == DONE);
  assign rsp_rdata      = (state_r == DONE) ? rdata_r : {XLEN{1'b0}};
  assign rsp_misaligned = (state_r == DONE) && misaligned_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table on an XLEN=32 instance,
// double-word cases on an XLEN=64 instance, and stall / reset-in-WAIT sequences.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // XLEN = 32 instance
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rsp_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_misaligned;

  mem_access_unit #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_misaligned(rsp_misaligned)
  );

  // XLEN = 64 instance
  logic        q_valid, q_ready, q_unsigned;
  logic [1:0]  q_size;
  logic [31:0] q_addr, m_addr;
  logic [63:0] q_wdata, m_wdata, m_rdata, r_rdata;
  logic        m_req_valid, m_we, r_valid, r_misaligned;
  logic [7:0]  m_be;

  mem_access_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(q_valid), .req_ready(q_ready), .req_store(1'b0),
    .req_size(q_size), .req_unsigned(q_unsigned), .req_addr(q_addr),
    .req_wdata(q_wdata), .mem_req_valid(m_req_valid), .mem_req_ready(1'b1),
    .mem_we(m_we), .mem_addr(m_addr), .mem_be(m_be), .mem_wdata(m_wdata),
    .mem_rsp_valid(1'b1), .mem_rdata(m_rdata), .rsp_valid(r_valid),
    .rsp_rdata(r_rdata), .rsp_misaligned(r_misaligned)
  );

  typedef struct {
    logic        store;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run32(input vec_t v, input string tag);
    int          cyc;
    logic        seen;
    logic        we_c;
    logic [31:0] a_c, w_c, mask;
    logic [3:0]  b_c;
    seen = 1'b0; we_c = 1'b0; a_c = 32'h0; w_c = 32'h0; b_c = 4'h0;
    @(negedge clk);
    chk({tag, " req_ready"}, req_ready, 1'b1);
    req_store = v.store; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; mem_rdata = v.rdata;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 12) begin
      if (mem_req_valid) begin
        seen = 1'b1; a_c = mem_addr; b_c = mem_be; we_c = mem_we; w_c = mem_wdata;
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, v.lat);
    chk({tag, " rsp_valid"}, rsp_valid, 1'b1);
    chk({tag, " misaligned"}, rsp_misaligned, v.fault);
    chk({tag, " rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, " mem_req seen"}, seen, !v.fault);
    if (!v.fault) begin
      chk({tag, " mem_addr"}, a_c, v.exp_addr);
      chk({tag, " mem_be"}, b_c, v.exp_be);
      chk({tag, " mem_we"}, we_c, v.store);
      if (v.store) begin
        for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{v.exp_be[i]}};
        chk({tag, " mem_wdata"}, w_c & mask, v.exp_wdata & mask);
      end
    end
    @(negedge clk);
    chk({tag, " single pulse"}, rsp_valid, 1'b0);
  endtask

  task automatic run64(input string tag, input logic [1:0] size, input logic [31:0] addr,
                       input logic [63:0] rdata, input logic fault, input logic [7:0] exp_be,
                       input logic [63:0] exp_rdata, input int lat);
    int         cyc;
    logic       seen;
    logic [7:0] b_c;
    logic [31:0] a_c;
    seen = 1'b0; b_c = 8'h0; a_c = 32'h0;
    @(negedge clk);
    q_size = size; q_unsigned = 1'b0; q_addr = addr; m_rdata = rdata; q_valid = 1'b1;
    @(negedge clk);
    q_valid = 1'b0;
    cyc = 1;
    while (!r_valid && cyc < 12) begin
      if (m_req_valid) begin
        seen = 1'b1; b_c = m_be; a_c = m_addr;
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " misaligned"}, r_misaligned, fault);
    chk({tag, " rdata"}, r_rdata, exp_rdata);
    chk({tag, " mem_req seen"}, seen, !fault);
    if (!fault) begin
      chk({tag, " mem_be"}, b_c, exp_be);
      chk({tag, " mem_addr"}, a_c, 32'h0000_0008);
    end
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_FF12, 1'b0,
                 32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80, 3};
    vecs[1]  = '{1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 1'b0,
                 32'h0000_2000, 4'b1100, 32'hABCD_0000, 32'h0, 2};
    vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 32'h5555_5555, 1'b1,
                 32'h0, 4'b0000, 32'h0, 32'h0, 1};
    vecs[3]  = '{1'b0, 2'b11, 1'b0, 32'h0000_4000, 32'h0, 32'h5555_5555, 1'b1,
                 32'h0, 4'b0000, 32'h0, 32'h0, 1};
    vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h0000_5002, 32'h0, 32'h80FF_FF12, 1'b0,
                 32'h0000_5000, 4'b1100, 32'h0, 32'h0000_80FF, 3};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0000_5000, 32'h0, 32'h1234_8001, 1'b0,
                 32'h0000_5000, 4'b0011, 32'h0, 32'hFFFF_8001, 3};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h0000_6004, 32'h0, 32'hDEAD_BEEF, 1'b0,
                 32'h0000_6004, 4'b1111, 32'h0, 32'hDEAD_BEEF, 3};
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h0000_7001, 32'h0000_00A5, 32'h0, 1'b0,
                 32'h0000_7000, 4'b0010, 32'h0000_A500, 32'h0, 2};
    vecs[8]  = '{1'b0, 2'b00, 1'b1, 32'h0000_1002, 32'h0, 32'h80FF_FF12, 1'b0,
                 32'h0000_1000, 4'b0100, 32'h0, 32'h0000_00FF, 3};
    vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'h0000_8000, 32'h1234_5678, 32'h0, 1'b0,
                 32'h0000_8000, 4'b1111, 32'h1234_5678, 32'h0, 2};
    vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h0000_9003, 32'h0000_FFFF, 32'h0, 1'b1,
                 32'h0, 4'b0000, 32'h0, 32'h0, 1};

    reset = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
    mem_rdata = 32'h0;
    q_valid = 1'b0; q_size = 2'b00; q_unsigned = 1'b0; q_addr = 32'h0;
    q_wdata = 64'h0; m_rdata = 64'h0;

    repeat (2) @(negedge clk);
    chk("reset req_ready", req_ready, 1'b1);
    chk("reset mem_req_valid", mem_req_valid, 1'b0);
    chk("reset mem_we", mem_we, 1'b0);
    chk("reset mem_be", mem_be, 4'h0);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset rsp_misaligned", rsp_misaligned, 1'b0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset64 req_ready", q_ready, 1'b1);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run32(vecs[i], $sformatf("vec%0d", i));

    run64("x64 ld dw", 2'b11, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 1'b0, 8'hFF,
          64'h0123_4567_89AB_CDEF, 3);
    run64("x64 ld w", 2'b10, 32'h0000_000C, 64'hF000_0001_0000_0000, 1'b0, 8'hF0,
          64'hFFFF_FFFF_F000_0001, 3);
    run64("x64 dw mis", 2'b11, 32'h0000_0004, 64'h1111_2222_3333_4444, 1'b1, 8'h00,
          64'h0, 1);

    // Memory stall with a stray read response while the request is pending.
    @(negedge clk);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    req_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0000_0104; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d mem_req_valid", i), mem_req_valid, 1'b1);
      chk($sformatf("stall%0d mem_addr", i), mem_addr, 32'h0000_0104);
      chk($sformatf("stall%0d mem_be", i), mem_be, 4'hF);
      chk($sformatf("stall%0d mem_we", i), mem_we, 1'b0);
      chk($sformatf("stall%0d rsp_valid", i), rsp_valid, 1'b0);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("stall released mem_req_valid", mem_req_valid, 1'b0);
    @(negedge clk);
    chk("stall rsp_valid", rsp_valid, 1'b1);
    chk("stall rdata", rsp_rdata, 32'h1234_5678);
    @(negedge clk);

    // Reset asserted while waiting for load data.
    mem_rsp_valid = 1'b0;
    req_size = 2'b00; req_addr = 32'h0000_1003; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("wait state req_ready", req_ready, 1'b0);
    chk("wait state mem_req_valid", mem_req_valid, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("async rst req_ready", req_ready, 1'b1);
    chk("async rst mem_req_valid", mem_req_valid, 1'b0);
    chk("async rst mem_be", mem_be, 4'h0);
    chk("async rst rsp_valid", rsp_valid, 1'b0);
    chk("async rst rsp_rdata", rsp_rdata, 32'h0);
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post rst no rsp", rsp_valid, 1'b0);
    run32(vecs[0], "after reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
